seq_tail_light_ctrl: RTL and testbench

//  Parametrised sequential tail-light controller for LAMPS lamps per side.

---
 rtl/seq_tail_light_ctrl_if.sv | 24 ++
 rtl/seq_tail_light_ctrl.sv | 170 +++++++++++++++++
 tb/tb_seq_tail_light_ctrl.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/seq_tail_light_ctrl_if.sv
// Signal bundle between the switch debouncers and the tail-light controller.
// The requests are plain levels with no valid/ready handshake. Each request is sampled on every clock edge.
interface seq_tail_light_ctrl_if #(
    parameter int LAMPS = 3
);
    logic             left;
    logic             right;
    logic             hazard;
    logic             brake;
    logic [LAMPS-1:0] l_lamp;
    logic [LAMPS-1:0] r_lamp;
    logic             busy;
    logic [2:0]       dbg_state;

    modport master (
        output left, right, hazard, brake,
        input  l_lamp, r_lamp, busy, dbg_state
    );

    modport slave (
        input  left, right, hazard, brake,
        output l_lamp, r_lamp, busy, dbg_state
    );
endinterface

// File: rtl/seq_tail_light_ctrl.sv
// Sequential tail-light controller: left/right/dual thermometer sweeps plus hazard flash.
// Optional brake overlay is built only when TBIRD_BRAKE_EN is defined.
module seq_tail_light_ctrl #(
    parameter int LAMPS    = 3,
    parameter int TICK_DIV = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    seq_tail_light_ctrl_if.slave  bus
);
    localparam int SW = $clog2(LAMPS + 1);
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] LEFT  = 3'd1;
    localparam logic [2:0] RIGHT = 3'd2;
    localparam logic [2:0] BOTH  = 3'd3;
    localparam logic [2:0] DARK  = 3'd4;
    localparam logic [2:0] HAZ   = 3'd5;

    logic [2:0]       state_q, state_d;
    logic [SW-1:0]    step_q, step_d;
    logic [TW-1:0]    tick_q, tick_d;
    logic             haz_on_q, haz_on_d;
    logic [LAMPS-1:0] l_lamp_q, l_lamp_d;
    logic [LAMPS-1:0] r_lamp_q, r_lamp_d;
    logic             busy_q, busy_d;
    logic [LAMPS-1:0] therm;
    logic             tick_end;

    assign tick_end = (tick_q == TW'(TICK_DIV - 1));

    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        tick_d   = tick_q;
        haz_on_d = haz_on_q;
        case (state_q)
            IDLE: begin
                tick_d   = '0;
                step_d   = '0;
                haz_on_d = 1'b0;
                if (bus.hazard) begin
                    state_d  = HAZ;
                    haz_on_d = 1'b1;
                end else if (bus.left && bus.right) begin
                    state_d = BOTH;
                    step_d  = SW'(1);
                end else if (bus.left) begin
                    state_d = LEFT;
                    step_d  = SW'(1);
                end else if (bus.right) begin
                    state_d = RIGHT;
                    step_d  = SW'(1);
                end
            end
            LEFT, RIGHT, BOTH, DARK: begin
                if (bus.hazard) begin
                    state_d  = HAZ;
                    haz_on_d = 1'b1;
                    tick_d   = '0;
                    step_d   = '0;
                end else if (!tick_end) begin
                    tick_d = tick_q + TW'(1);
                end else begin
                    tick_d = '0;
                    if (state_q == DARK) begin
                        state_d = IDLE;
                    end else if (step_q == SW'(LAMPS)) begin
                        state_d = DARK;
                        step_d  = '0;
                    end else begin
                        step_d = step_q + SW'(1);
                    end
                end
            end
            HAZ: begin
                // An on-phase is always followed by an off-phase, so a dropped request never cuts a flash short.
                if (!tick_end) begin
                    tick_d = tick_q + TW'(1);
                end else begin
                    tick_d = '0;
                    if (haz_on_q) begin
                        haz_on_d = 1'b0;
                    end else if (bus.hazard) begin
                        haz_on_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d  = IDLE;
                step_d   = '0;
                tick_d   = '0;
                haz_on_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        therm = '0;
        for (int i = 0; i < LAMPS; i++) begin
            therm[i] = (i < int'(step_d));
        end
    end

    // Lamps are decoded from the next state so that a request shows on the lamps at the same edge that accepts it.
    always_comb begin
        l_lamp_d = '0;
        r_lamp_d = '0;
        case (state_d)
            LEFT:  l_lamp_d = therm;
            RIGHT: r_lamp_d = therm;
            BOTH: begin
                l_lamp_d = therm;
                r_lamp_d = therm;
            end
            HAZ: begin
                l_lamp_d = {LAMPS{haz_on_d}};
                r_lamp_d = {LAMPS{haz_on_d}};
            end
            default: ;
        endcase
`ifdef TBIRD_BRAKE_EN
        if (bus.brake) begin
            case (state_d)
                IDLE, DARK: begin
                    l_lamp_d = '1;
                    r_lamp_d = '1;
                end
                LEFT:    r_lamp_d = '1;
                RIGHT:   l_lamp_d = '1;
                default: ;
            endcase
        end
`endif
        busy_d = (state_d != IDLE);
    end

`ifndef TBIRD_BRAKE_EN
    logic unused_brake;
    assign unused_brake = bus.brake;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            step_q   <= '0;
            tick_q   <= '0;
            haz_on_q <= 1'b0;
            l_lamp_q <= '0;
            r_lamp_q <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            tick_q   <= tick_d;
            haz_on_q <= haz_on_d;
            l_lamp_q <= l_lamp_d;
            r_lamp_q <= r_lamp_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.l_lamp    = l_lamp_q;
    assign bus.r_lamp    = r_lamp_q;
    assign bus.busy      = busy_q;
    assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_seq_tail_light_ctrl.sv
// Directed bench for seq_tail_light_ctrl: one 3-lamp/2-tick instance and one 5-lamp/1-tick instance.
module tb_seq_tail_light_ctrl;
    logic clk;
    logic reset;
    int   total;
    int   bad;

`ifdef TBIRD_BRAKE_EN
    localparam logic [2:0] BRK = 3'b111;
`else
    localparam logic [2:0] BRK = 3'b000;
`endif

    logic [2:0] pat_a [9]  = '{3'b001, 3'b001, 3'b011, 3'b011, 3'b111, 3'b111, 3'b000, 3'b000, 3'b000};
    logic       busy_a [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [4:0] pat_b [7]  = '{5'b00001, 5'b00011, 5'b00111, 5'b01111, 5'b11111, 5'b00000, 5'b00000};

    seq_tail_light_ctrl_if #(.LAMPS(3)) if_a ();
    seq_tail_light_ctrl_if #(.LAMPS(5)) if_b ();

    seq_tail_light_ctrl #(.LAMPS(3), .TICK_DIV(2)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (if_a)
    );

    seq_tail_light_ctrl #(.LAMPS(5), .TICK_DIV(1)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (if_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        assert (got === exp)
        else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_a(input string tag, input logic [2:0] l, input logic [2:0] r, input logic b);
        chk({tag, ".l"}, 8'(if_a.l_lamp), 8'(l));
        chk({tag, ".r"}, 8'(if_a.r_lamp), 8'(r));
        chk({tag, ".busy"}, 8'(if_a.busy), 8'(b));
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        if_a.left = 1'b0; if_a.right = 1'b0; if_a.hazard = 1'b0; if_a.brake = 1'b0;
        if_b.left = 1'b0; if_b.right = 1'b0; if_b.hazard = 1'b0; if_b.brake = 1'b0;
        tick();
        tick();
        chk_a("reset_a", 3'b000, 3'b000, 1'b0);
        chk("reset_b.l", 8'(if_b.l_lamp), 8'h00);
        chk("reset_b.busy", 8'(if_b.busy), 8'h00);
        reset = 1'b0;

        // reset in the middle of a dual sweep
        if_a.left = 1'b1; if_a.right = 1'b1;
        tick();
        chk_a("both_s1", 3'b001, 3'b001, 1'b1);
        if_a.left = 1'b0; if_a.right = 1'b0;
        tick();
        tick();
        chk_a("both_s2", 3'b011, 3'b011, 1'b1);
        #2 reset = 1'b1;
        #1 chk_a("async_rst", 3'b000, 3'b000, 1'b0);
        #2 reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_a("idle_after_rst", 3'b000, 3'b000, 1'b0);
        end

        // left held for 20 clocks, then released mid-sweep
        if_a.left = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            chk_a($sformatf("left_held%0d", k), pat_a[k % 9], 3'b000, busy_a[k % 9]);
        end
        if_a.left = 1'b0;
        for (int k = 2; k < 9; k++) begin
            tick();
            chk_a($sformatf("left_commit%0d", k), pat_a[k], 3'b000, busy_a[k]);
        end

        // one-clock dual pulse commits a full lockstep sweep
        if_a.left = 1'b1; if_a.right = 1'b1;
        tick();
        chk_a("pulse0", pat_a[0], pat_a[0], busy_a[0]);
        if_a.left = 1'b0; if_a.right = 1'b0;
        for (int k = 1; k < 9; k++) begin
            tick();
            chk_a($sformatf("pulse%0d", k), pat_a[k], pat_a[k], busy_a[k]);
        end
        tick();
        chk_a("pulse_idle", 3'b000, 3'b000, 1'b0);

        // right sweep aborted by hazard at step 2
        if_a.right = 1'b1;
        tick();
        chk_a("right_s1", 3'b000, 3'b001, 1'b1);
        if_a.right = 1'b0;
        tick();
        tick();
        chk_a("right_s2", 3'b000, 3'b011, 1'b1);
        if_a.hazard = 1'b1;
        tick(); chk_a("haz_on0",  3'b111, 3'b111, 1'b1);
        tick(); chk_a("haz_on1",  3'b111, 3'b111, 1'b1);
        tick(); chk_a("haz_off0", 3'b000, 3'b000, 1'b1);
        tick(); chk_a("haz_off1", 3'b000, 3'b000, 1'b1);
        tick(); chk_a("haz_on2",  3'b111, 3'b111, 1'b1);
        if_a.hazard = 1'b0;
        tick(); chk_a("haz_on3",  3'b111, 3'b111, 1'b1);
        tick(); chk_a("haz_tail0", 3'b000, 3'b000, 1'b1);
        tick(); chk_a("haz_tail1", 3'b000, 3'b000, 1'b1);
        tick(); chk_a("haz_idle", 3'b000, 3'b000, 1'b0);

        // 5 lamps, one clock per step
        if_b.left = 1'b1;
        for (int k = 0; k < 14; k++) begin
            tick();
            chk($sformatf("b_left%0d.l", k), 8'(if_b.l_lamp), 8'(pat_b[k % 7]));
            chk($sformatf("b_left%0d.r", k), 8'(if_b.r_lamp), 8'h00);
            chk($sformatf("b_left%0d.busy", k), 8'(if_b.busy), 8'((k % 7) != 6));
        end
        if_b.left = 1'b0;
        tick();
        chk("b_idle.l", 8'(if_b.l_lamp), 8'h00);
        chk("b_idle.busy", 8'(if_b.busy), 8'h00);

        // brake overlay, and its absence when not built
        if_a.brake = 1'b1;
        tick();
        chk_a("brk_idle", BRK, BRK, 1'b0);
        if_a.left = 1'b1;
        tick();
        chk_a("brk_left_s1", 3'b001, BRK, 1'b1);
        if_a.left = 1'b0;
        tick(); chk_a("brk_left_s1b", 3'b001, BRK, 1'b1);
        tick(); chk_a("brk_left_s2",  3'b011, BRK, 1'b1);
        if_a.hazard = 1'b1;
        tick(); chk_a("brk_haz_on0",  3'b111, 3'b111, 1'b1);
        tick(); chk_a("brk_haz_on1",  3'b111, 3'b111, 1'b1);
        tick(); chk_a("brk_haz_off0", 3'b000, 3'b000, 1'b1);
        if_a.hazard = 1'b0;
        tick(); chk_a("brk_haz_off1", 3'b000, 3'b000, 1'b1);
        tick(); chk_a("brk_idle2", BRK, BRK, 1'b0);
        if_a.brake = 1'b0;
        tick(); chk_a("brk_release", 3'b000, 3'b000, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
